// File: rtl/nios_system_sysid_checker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// nios_system_sysid_checker: reads sysid words 0/1 over Avalon-MM and checks
// them against build-time constants.                           Revision 1.0
// ---------------------------------------------------------------------------
module nios_system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1480905656,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] id_value,
  output logic [31:0] timestamp_value,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        pass,
  output logic        timeout_err
);

  localparam logic [15:0] C_TIMEOUT = 16'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RD_ID  = 2'd1,
    S_RD_TS  = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] id_value_q, id_value_d;
  logic [31:0] ts_value_q, ts_value_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        tmo_q, tmo_d;
  logic        auto_q, auto_d;

  logic        w_reading;
  logic        w_complete;
  logic        w_abort;
  logic [15:0] w_cnt_inc;

  always_comb begin
    w_reading  = (state_q == S_RD_ID) || (state_q == S_RD_TS);
    w_complete = w_reading && !avm_waitrequest;
    w_cnt_inc  = cnt_q + 16'd1;
    // Abort on the stalled edge that would bring the count up to the limit.
    w_abort    = w_reading && avm_waitrequest && (w_cnt_inc == C_TIMEOUT);

    state_d    = state_q;
    cnt_d      = cnt_q;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;
    id_ok_d    = id_ok_q;
    ts_ok_d    = ts_ok_q;
    tmo_d      = tmo_q;
    auto_d     = auto_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = 16'd0;
        if (start || auto_q) begin
          state_d = S_RD_ID;
          auto_d  = 1'b0;
          id_ok_d = 1'b0;
          ts_ok_d = 1'b0;
          tmo_d   = 1'b0;
        end
      end
      S_RD_ID: begin
        if (w_complete) begin
          id_value_d = avm_readdata;
          id_ok_d    = (avm_readdata == EXPECTED_ID);
          cnt_d      = 16'd0;
          state_d    = S_RD_TS;
        end else if (w_abort) begin
          tmo_d   = 1'b1;
          state_d = S_FINISH;
        end else begin
          cnt_d = w_cnt_inc;
        end
      end
      S_RD_TS: begin
        if (w_complete) begin
          ts_value_d = avm_readdata;
          ts_ok_d    = (avm_readdata == EXPECTED_TIMESTAMP);
          state_d    = S_FINISH;
        end else if (w_abort) begin
          tmo_d   = 1'b1;
          state_d = S_FINISH;
        end else begin
          cnt_d = w_cnt_inc;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 16'd0;
      id_value_q <= 32'd0;
      ts_value_q <= 32'd0;
      id_ok_q    <= 1'b0;
      ts_ok_q    <= 1'b0;
      tmo_q      <= 1'b0;
      auto_q     <= AUTO_START;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
      id_ok_q    <= id_ok_d;
      ts_ok_q    <= ts_ok_d;
      tmo_q      <= tmo_d;
      auto_q     <= auto_d;
    end
  end

  // Bus strobes decode straight from state so reset drops them asynchronously.
  assign avm_read        = w_reading;
  assign avm_address     = (state_q == S_RD_TS);
  assign busy            = (state_q != S_IDLE);
  assign done            = (state_q == S_FINISH);
  assign id_value        = id_value_q;
  assign timestamp_value = ts_value_q;
  assign id_ok           = id_ok_q;
  assign ts_ok           = ts_ok_q;
  assign timeout_err     = tmo_q;
  assign pass            = id_ok_q & ts_ok_q & ~tmo_q;

endmodule
`default_nettype wire

// File: tb/tb_nios_system_sysid_checker.sv
`default_nettype none
// Directed bench for nios_system_sysid_checker with a queued scoreboard
// popped by a monitor on every done pulse.
module tb_nios_system_sysid_checker;

  localparam logic [31:0] C_TS = 32'd1480905656;

  typedef struct packed {
    logic        id_ok;
    logic        ts_ok;
    logic        pass;
    logic        tmo;
    logic [31:0] idv;
    logic [31:0] tsv;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        busy, done, id_ok, ts_ok, pass, timeout_err;
  logic [31:0] id_value, timestamp_value;

  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        sb_q[$];

  // Slave model controls
  logic [31:0] d0, d1;
  int          stall0, stall1;
  bit          hang1;
  int          scnt;
  bit          stable_en;
  logic        stalled_prev;
  logic        addr_prev;

  always #5 clock = ~clock;

  nios_system_sysid_checker #(
    .EXPECTED_ID       (32'd0),
    .EXPECTED_TIMESTAMP(C_TS),
    .TIMEOUT_CYCLES    (4),
    .AUTO_START        (1'b1)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata   (avm_readdata),
    .busy           (busy),
    .done           (done),
    .id_value       (id_value),
    .timestamp_value(timestamp_value),
    .id_ok          (id_ok),
    .ts_ok          (ts_ok),
    .pass           (pass),
    .timeout_err    (timeout_err)
  );

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) scnt <= 0;
    else if (avm_read && avm_waitrequest) scnt <= scnt + 1;
    else scnt <= 0;
  end

  always_comb begin
    avm_waitrequest = 1'b0;
    if (avm_read) begin
      if (avm_address) avm_waitrequest = hang1 || (scnt < stall1);
      else             avm_waitrequest = (scnt < stall0);
    end
    avm_readdata = avm_address ? d1 : d0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clock) begin
    if (reset_n === 1'b1 && done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("id_ok", {31'd0, id_ok}, {31'd0, e.id_ok});
        check("ts_ok", {31'd0, ts_ok}, {31'd0, e.ts_ok});
        check("pass", {31'd0, pass}, {31'd0, e.pass});
        check("timeout_err", {31'd0, timeout_err}, {31'd0, e.tmo});
        check("id_value", id_value, e.idv);
        check("timestamp_value", timestamp_value, e.tsv);
      end
    end
  end

  // Address/strobe must hold across stalled edges
  always @(posedge clock) begin
    stalled_prev <= (reset_n === 1'b1) && avm_read && avm_waitrequest;
    addr_prev    <= avm_address;
  end

  always @(negedge clock) begin
    if (stable_en && stalled_prev) begin
      check("stall_read_held", {31'd0, avm_read}, 32'd1);
      check("stall_addr_held", {31'd0, avm_address}, {31'd0, addr_prev});
    end
  end

  task automatic run(input exp_t e, input int exp_lat, input bit do_start,
                     input bit seq_chk, input int pulse_at);
    int lat;
    sb_q.push_back(e);
    if (do_start) begin
      @(negedge clock);
      start = 1'b1;
    end
    lat = 0;
    do begin
      @(posedge clock);
      lat++;
      @(negedge clock);
      start = (lat == pulse_at);
      if (seq_chk && lat == 1) begin
        check("rd0_read", {31'd0, avm_read}, 32'd1);
        check("rd0_addr", {31'd0, avm_address}, 32'd0);
      end
      if (seq_chk && lat == 2) begin
        check("rd1_read", {31'd0, avm_read}, 32'd1);
        check("rd1_addr", {31'd0, avm_address}, 32'd1);
      end
    end while (done !== 1'b1 && lat < 200);
    start = 1'b0;
    check("done_seen", {31'd0, done}, 32'd1);
    check("latency", lat, exp_lat);
    @(negedge clock);
    check("idle_after_done", {31'd0, busy}, 32'd0);
    check("pass_hold", {31'd0, pass}, {31'd0, e.pass});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e_ok;
    reset_n = 1'b0; start = 1'b0;
    d0 = 32'd0; d1 = C_TS;
    stall0 = 0; stall1 = 0; hang1 = 1'b0; stable_en = 1'b0;
    e_ok = '{id_ok: 1'b1, ts_ok: 1'b1, pass: 1'b1, tmo: 1'b0, idv: 32'd0, tsv: C_TS};

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_read", {31'd0, avm_read}, 32'd0);
    check("rst_addr", {31'd0, avm_address}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_pass", {31'd0, pass}, 32'd0);
    check("rst_timeout", {31'd0, timeout_err}, 32'd0);
    check("rst_id_value", id_value, 32'd0);
    check("rst_ts_value", timestamp_value, 32'd0);

    // Auto-start after reset release
    reset_n = 1'b1;
    run(e_ok, 3, 1'b0, 1'b1, 0);

    // Zero-wait start-triggered check
    run(e_ok, 3, 1'b1, 1'b1, 0);

    // Wrong timestamp
    d1 = 32'h1234_5678;
    run('{id_ok: 1'b1, ts_ok: 1'b0, pass: 1'b0, tmo: 1'b0, idv: 32'd0, tsv: 32'h1234_5678},
        3, 1'b1, 1'b0, 0);

    // Three stalled cycles on each read
    d1 = C_TS; stall0 = 3; stall1 = 3; stable_en = 1'b1;
    run(e_ok, 9, 1'b1, 1'b0, 0);
    stable_en = 1'b0; stall0 = 0; stall1 = 0;

    // Timeout on word 1: earlier timestamp capture is retained
    hang1 = 1'b1;
    run('{id_ok: 1'b1, ts_ok: 1'b0, pass: 1'b0, tmo: 1'b1, idv: 32'd0, tsv: C_TS},
        6, 1'b1, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("read_low_after_abort", {31'd0, avm_read}, 32'd0);
    end
    hang1 = 1'b0;

    // Start pulse while in RD_TS is dropped
    stall1 = 2;
    run(e_ok, 5, 1'b1, 1'b0, 2);
    repeat (6) @(negedge clock);
    check("no_second_check", {31'd0, busy}, 32'd0);
    stall1 = 0;

    // Reset asserted mid RD_ID
    stall0 = 20;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    check("pre_reset_read", {31'd0, avm_read}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_read", {31'd0, avm_read}, 32'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_done", {31'd0, done}, 32'd0);
    check("async_rst_id_ok", {31'd0, id_ok}, 32'd0);
    check("async_rst_ts_ok", {31'd0, ts_ok}, 32'd0);
    check("async_rst_ts_value", timestamp_value, 32'd0);
    stall0 = 0;
    @(negedge clock);
    reset_n = 1'b1;
    run(e_ok, 3, 1'b0, 1'b0, 0);

    repeat (4) @(negedge clock);
    check("scoreboard_empty", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
